// File: rtl/t5_wbarb_if.sv
// rtl/t5_wbarb_if.sv - word-addressed bus bundle shared by the arbiter's masters and memory slave
interface t5_wbarb_if #(
  parameter int XLEN = 32
);
  logic [29:0]     adr;
  logic [XLEN-1:0] dto;
  logic [XLEN-1:0] dti;
  logic [3:0]      sel;
  logic            stb;
  logic            wre;
  logic            ack;
  logic            err;

  modport master (
    output adr, dto, sel, stb, wre,
    input  dti, ack, err
  );

  modport slave (
    input  adr, dto, sel, stb, wre,
    output dti, ack, err
  );
endinterface

// File: rtl/t5_wbarb.sv
// rtl/t5_wbarb.sv - two-master (instruction/data) arbiter onto one memory port with no-ack watchdog
module t5_wbarb #(
  parameter int XLEN = 32,
  parameter int TMO  = 16,
  parameter bit DPRI = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  t5_wbarb_if.slave  iwb,
  t5_wbarb_if.slave  dwb,
  t5_wbarb_if.master mwb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TMO - 1);
  localparam logic       LAST_I   = 1'b0;
  localparam logic       LAST_D   = 1'b1;

  state_t     state, state_n;
  logic       last, last_n;
  logic [7:0] cnt, cnt_n;
  logic       in_i, in_d, expired;
  logic       unused_ok;

  assign in_i    = (state == IGNT);
  assign in_d    = (state == DGNT);
  assign expired = (cnt == CNT_LAST) && !mwb.ack;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
      last  <= LAST_I;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (iwb.stb && dwb.stb) begin
          // On contention the master not served last wins, unless data has priority
          if (DPRI || (last == LAST_I)) begin
            state_n = DGNT;
            last_n  = LAST_D;
          end else begin
            state_n = IGNT;
            last_n  = LAST_I;
          end
        end else if (iwb.stb) begin
          state_n = IGNT;
          last_n  = LAST_I;
        end else if (dwb.stb) begin
          state_n = DGNT;
          last_n  = LAST_D;
        end
      end
      IGNT: begin
        if (!iwb.stb || mwb.ack || expired) state_n = IDLE;
        else                                cnt_n   = cnt + 8'd1;
      end
      DGNT: begin
        if (!dwb.stb || mwb.ack || expired) state_n = IDLE;
        else                                cnt_n   = cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory side is a pure mux on state so a reset drops it without waiting for a clock
  assign mwb.adr = in_i ? iwb.adr : (in_d ? dwb.adr : '0);
  assign mwb.sel = in_i ? iwb.sel : (in_d ? dwb.sel : '0);
  assign mwb.wre = (in_i && iwb.wre) || (in_d && dwb.wre);
  assign mwb.stb = (in_i && iwb.stb) || (in_d && dwb.stb);
  assign mwb.dto = in_d ? dwb.dto : '0;

  assign iwb.ack = in_i && mwb.ack;
  assign dwb.ack = in_d && mwb.ack;
  assign iwb.err = in_i && expired;
  assign dwb.err = in_d && expired;

  assign iwb.dti = mwb.dti[31:0];
  assign dwb.dti = mwb.dti;

  assign unused_ok = ^{iwb.dto, mwb.err};

endmodule
